// File: rtl/meas_sequencer_if.sv
// Handshake/data bundle between the measurement sequencer, the clock manager and the level-sensor interface.
// The slave modport is the sequencer's view; the master modport is the view of whatever drives the sequencer.
interface meas_sequencer_if #(
    parameter int DATA_W = 12
);
    logic              tick_1khz;
    logic              tick_1hz;
    logic              enable;
    logic              meas_start;
    logic              meas_done;
    logic [DATA_W-1:0] meas_data;
    logic [DATA_W-1:0] level;
    logic              level_valid;
    logic              timeout_err;
    logic              busy;
    logic [7:0]        overrun_cnt;

    modport slave (
        input  tick_1khz, tick_1hz, enable, meas_done, meas_data,
        output meas_start, level, level_valid, timeout_err, busy, overrun_cnt
    );

    modport master (
        output tick_1khz, tick_1hz, enable, meas_done, meas_data,
        input  meas_start, level, level_valid, timeout_err, busy, overrun_cnt
    );
endinterface

// File: rtl/meas_sequencer.sv
// Once-per-second level measurement sequencer with a ms timeout; optional MEAS_AVG_EN publishes the mean of 4 samples.
// Latency: tick_1hz -> meas_start 1 cycle, meas_done -> level_valid 2 cycles; 1 Hz ticks arriving while busy are dropped and counted.
module meas_sequencer #(
    parameter int DATA_W     = 12,
    parameter int TIMEOUT_MS = 50
) (
    input  logic            clk_100MHz,
    input  logic            reset_n,
    meas_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STORE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_MS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_ms_cnt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_level;
    logic              r_level_valid;
    logic              r_timeout_err;
    logic [7:0]        r_ovr_cnt;

    logic              w_busy;
    logic              w_tick_last;
    logic              w_timeout;
    logic              w_store;
    logic              w_publish;
    logic [DATA_W-1:0] w_pub_val;

    assign w_busy      = (r_state != S_IDLE);
    assign w_tick_last = bus.tick_1khz && (r_ms_cnt == TMO_LAST);
    // A coincident meas_done takes priority over the timeout tick.
    assign w_timeout   = (r_state == S_WAIT) && w_tick_last && !bus.meas_done;
    assign w_store     = (r_state == S_STORE);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.tick_1hz && bus.enable) begin
                    w_next = S_START;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.meas_done) begin
                    w_next = S_STORE;
                end else if (w_tick_last) begin
                    w_next = S_IDLE;
                end
            end
            S_STORE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_ms_cnt <= 8'd0;
        end else if (r_state == S_START) begin
            r_ms_cnt <= 8'd0;
        end else if ((r_state == S_WAIT) && bus.tick_1khz) begin
            r_ms_cnt <= r_ms_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sample <= '0;
        end else if ((r_state == S_WAIT) && bus.meas_done) begin
            r_sample <= bus.meas_data;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr_cnt <= 8'd0;
        end else if (w_busy && bus.tick_1hz && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

`ifdef MEAS_AVG_EN
    logic [DATA_W+1:0] r_acc;
    logic [1:0]        r_acc_cnt;
    logic [DATA_W+1:0] w_sum;

    // Four DATA_W samples fit the two guard bits, so the sum never wraps.
    assign w_sum     = r_acc + {2'b00, r_sample};
    assign w_publish = w_store && (r_acc_cnt == 2'd3);
    assign w_pub_val = w_sum[DATA_W+1:2];

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_acc_cnt <= 2'd0;
        end else if (w_timeout || w_publish) begin
            r_acc     <= '0;
            r_acc_cnt <= 2'd0;
        end else if (w_store) begin
            r_acc     <= w_sum;
            r_acc_cnt <= r_acc_cnt + 2'd1;
        end
    end
`else
    assign w_publish = w_store;
    assign w_pub_val = r_sample;
`endif

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_level       <= '0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= w_publish;
            if (w_publish) begin
                r_level <= w_pub_val;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (w_publish) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign bus.meas_start  = (r_state == S_START);
    assign bus.busy        = w_busy;
    assign bus.level       = r_level;
    assign bus.level_valid = r_level_valid;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun_cnt = r_ovr_cnt;
endmodule

// File: tb/tb_meas_sequencer.sv
// Randomized bench for meas_sequencer against a transaction-level model of published level, error flag and overrun count.
`timescale 1ns/1ps
module tb_meas_sequencer;
    localparam int DW  = 12;
    localparam int TMO = 50;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;

    meas_sequencer_if #(.DATA_W(DW)) bus ();

    meas_sequencer #(.DATA_W(DW), .TIMEOUT_MS(TMO)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [DW-1:0] exp_level;
    bit            exp_err;
    int            exp_ovr;
    int            avg_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit exp_vld, input bit exp_busy);
        check({tag, "/level"},       32'(bus.level),       32'(exp_level));
        check({tag, "/level_valid"}, 32'(bus.level_valid), 32'(exp_vld));
        check({tag, "/timeout_err"}, 32'(bus.timeout_err), 32'(exp_err));
        check({tag, "/busy"},        32'(bus.busy),        32'(exp_busy));
        check({tag, "/overrun_cnt"}, 32'(bus.overrun_cnt), 32'(exp_ovr));
    endtask

    task automatic model_reset();
        exp_level = '0;
        exp_err   = 1'b0;
        exp_ovr   = 0;
        avg_q.delete();
    endtask

    task automatic model_ovr();
        if (exp_ovr < 255) exp_ovr++;
    endtask

    task automatic model_store(input logic [DW-1:0] d, output bit pub);
`ifdef MEAS_AVG_EN
        int sum;
        avg_q.push_back(int'(d));
        pub = 1'b0;
        if (avg_q.size() == 4) begin
            sum = 0;
            foreach (avg_q[i]) sum += avg_q[i];
            exp_level = DW'(sum / 4);
            exp_err   = 1'b0;
            pub       = 1'b1;
            avg_q.delete();
        end
`else
        exp_level = d;
        exp_err   = 1'b0;
        pub       = 1'b1;
`endif
    endtask

    // mode 0: meas_done after n_ticks ms; mode 1: meas_done on the timeout tick; mode 2: no meas_done
    task automatic meas_cycle(input int n_ticks, input int mode, input logic [DW-1:0] d,
                              input int n_ovr, input bit drop_en);
        int ticks;
        bit pub;
        bus.enable   = 1'b1;
        bus.tick_1hz = 1'b1;
        check("start_before_edge", 32'(bus.meas_start), 32'd0);
        cyc();
        bus.tick_1hz = 1'b0;
        check("meas_start", 32'(bus.meas_start), 32'd1);
        check("busy_start", 32'(bus.busy), 32'd1);
        cyc();
        check("meas_start_width", 32'(bus.meas_start), 32'd0);
        if (drop_en) bus.enable = 1'b0;
        for (int k = 0; k < n_ovr; k++) begin
            bus.tick_1hz = 1'b1;
            cyc();
            bus.tick_1hz = 1'b0;
            model_ovr();
            cyc();
        end
        check("overrun_cnt", 32'(bus.overrun_cnt), 32'(exp_ovr));
        ticks = (mode == 0) ? n_ticks : TMO;
        for (int k = 1; k <= ticks; k++) begin
            bus.tick_1khz = 1'b1;
            if (mode == 1 && k == TMO) begin
                bus.meas_done = 1'b1;
                bus.meas_data = d;
            end
            cyc();
            bus.tick_1khz = 1'b0;
            bus.meas_done = 1'b0;
            if (k == ticks - 1) check("busy_wait", 32'(bus.busy), 32'd1);
            if (k < ticks) cyc();
        end
        if (mode == 2) begin
            exp_err = 1'b1;
            avg_q.delete();
            check_outs("timeout", 1'b0, 1'b0);
            cyc();
            check("timeout_no_valid", 32'(bus.level_valid), 32'd0);
        end else begin
            if (mode == 0) begin
                cyc();
                bus.meas_done = 1'b1;
                bus.meas_data = d;
                cyc();
                bus.meas_done = 1'b0;
            end
            check_outs("store", 1'b0, 1'b1);
            model_store(d, pub);
            cyc();
            check_outs("publish", pub, 1'b0);
            cyc();
            check("valid_width", 32'(bus.level_valid), 32'd0);
        end
        bus.enable = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        bus.tick_1khz = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.enable    = 1'b0;
        bus.meas_done = 1'b0;
        bus.meas_data = '0;
        model_reset();
        cyc();
        cyc();
        check_outs("reset", 1'b0, 1'b0);
        check("reset/meas_start", 32'(bus.meas_start), 32'd0);
        reset_n = 1'b1;
        cyc();

        meas_cycle(10, 0, 12'h3A5, 0, 1'b0);
        meas_cycle(0, 2, '0, 0, 1'b0);
        meas_cycle(7, 0, 12'h1F0, 0, 1'b0);
        meas_cycle(0, 1, 12'h5C3, 0, 1'b0);
        meas_cycle(4, 0, 12'h0AB, 3, 1'b1);

        bus.enable   = 1'b0;
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
        check_outs("disabled_tick", 1'b0, 1'b0);
        check("disabled_tick/meas_start", 32'(bus.meas_start), 32'd0);
        bus.enable    = 1'b1;
        bus.meas_done = 1'b1;
        bus.meas_data = 12'hFFF;
        cyc();
        bus.meas_done = 1'b0;
        cyc();
        check_outs("idle_done_ignored", 1'b0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            d = DW'($urandom);
            meas_cycle($urandom_range(1, TMO - 1), $urandom_range(0, 2), d,
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        meas_cycle(0, 2, '0, 0, 1'b0);
        meas_cycle(3, 0, 12'd100, 0, 1'b0);
        meas_cycle(5, 0, 12'd200, 0, 1'b0);
        meas_cycle(9, 0, 12'd300, 0, 1'b0);
        meas_cycle(2, 0, 12'd401, 0, 1'b0);

        meas_cycle(3, 0, 12'h777, 300, 1'b0);

        bus.enable   = 1'b1;
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            bus.tick_1khz = 1'b1;
            cyc();
            bus.tick_1khz = 1'b0;
            cyc();
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs("mid_wait_reset", 1'b0, 1'b0);
        check("mid_wait_reset/meas_start", 32'(bus.meas_start), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        bus.meas_done = 1'b1;
        bus.meas_data = 12'h321;
        cyc();
        bus.meas_done = 1'b0;
        check_outs("late_done_1", 1'b0, 1'b0);
        cyc();
        check_outs("late_done_2", 1'b0, 1'b0);
        meas_cycle(6, 0, 12'h456, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
